// File: rtl/dmem_seq.sv
// dmem_seq -- command-driven burst sequencer for the DMem data memory tile.
//
// Takes one burst command at a time (direction, port, base, stride, length)
// and drives the DMem address, write enable and cfgdat select lines every
// cycle until the burst completes.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   cmd_valid  command offered; cmd_ready high only in IDLE
//   cmd_op     [1] 0 = write into DMem, 1 = read out; [0] 0 = vertical, 1 = horizontal
//   cmd_base   first address
//   cmd_stride address increment per beat (wraps modulo 2**AddrDMEM)
//   cmd_len    beat count (0 = go straight to DONE)
//   stall      freezes the burst while high in RUN
//   r_addr     DMem read address (same value as w_addr)
//   w_addr     DMem write address
//   we_ram     DMem write enable
//   cfgdat     [3:2] output select, [1:0] input select
//   beat_valid a beat takes place this cycle
//   busy       burst in progress
//   done       one-cycle completion pulse
//
// Optional feature, macro DMEM_SEQ_ABORT_EN:
//   abort      (in)  in RUN, end the burst now; the current cycle does no beat
//   aborted    (out) high together with done when the burst was aborted

module dmem_seq #(
  parameter int AddrDMEM = 8,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [AddrDMEM-1:0] cmd_base,
  input  logic [AddrDMEM-1:0] cmd_stride,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                stall,
`ifdef DMEM_SEQ_ABORT_EN
  input  logic                abort,
  output logic                aborted,
`endif
  output logic [AddrDMEM-1:0] r_addr,
  output logic [AddrDMEM-1:0] w_addr,
  output logic                we_ram,
  output logic [3:0]          cfgdat,
  output logic                beat_valid,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [AddrDMEM-1:0] addr_q, addr_d;
  logic [AddrDMEM-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [1:0]          op_q, op_d;
  logic                abort_w;

`ifdef DMEM_SEQ_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_w = abort;
  // Remembers that RUN was left through abort so DONE can flag it.
  assign aborted_d = (state_q == S_RUN) && abort;
  assign aborted   = (state_q == S_DONE) && aborted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted_q <= 1'b0;
    else      aborted_q <= aborted_d;
  end
`else
  assign abort_w = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      op_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      op_q        <= op_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    op_d        = op_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          stride_d    = cmd_stride;
          addr_d      = cmd_base;
          remaining_d = cmd_len;
          state_d     = (cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          // Abort ends the burst with address and count frozen.
          state_d = S_DONE;
        end else if (!stall) begin
          addr_d      = addr_q + stride_q;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    beat_valid = 1'b0;
    we_ram     = 1'b0;
    cfgdat     = 4'b0000;
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_RUN: begin
        busy       = 1'b1;
        beat_valid = !stall && !abort_w;
        we_ram     = !op_q[1] && !stall && !abort_w;
        // Select stays put through stalls: only op_q feeds it.
        cfgdat     = op_q[1] ? {1'b1, op_q[0], 2'b00} : {2'b00, 1'b1, op_q[0]};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign r_addr = addr_q;
  assign w_addr = addr_q;

endmodule

// File: tb/tb_dmem_seq.sv
module tb_dmem_seq;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] base;
    logic [7:0] stride;
    logic [7:0] len;
  } cmd_t;

  typedef struct packed {
    logic valid;
    logic abort;
    logic stall;
    cmd_t c;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_base = 8'h00;
  logic [7:0] cmd_stride = 8'h00;
  logic [7:0] cmd_len = 8'h00;
  logic       stall = 1'b0;
  logic [7:0] r_addr, w_addr;
  logic       we_ram, beat_valid, busy, done;
  logic [3:0] cfgdat;
  logic       aborted_s;
`ifdef DMEM_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
  assign aborted_s = aborted;
`else
  assign aborted_s = 1'b0;
`endif

  dmem_seq #(.AddrDMEM(8), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_len    (cmd_len),
    .stall      (stall),
`ifdef DMEM_SEQ_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .r_addr     (r_addr),
    .w_addr     (w_addr),
    .we_ram     (we_ram),
    .cfgdat     (cfgdat),
    .beat_valid (beat_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_addr = 8'h00;

  // Vector layout: {ready, busy, done, beat, we, aborted, cfgdat[3:0], r_addr, w_addr}
  stim_t       stim_q[$];
  logic [25:0] exp_q[$];
  logic [25:0] act_q[$];

  function automatic logic [25:0] mk(input logic rdy, input logic bsy, input logic dn,
                                     input logic bt, input logic we, input logic ab,
                                     input logic [3:0] cfg, input logic [7:0] a);
    return {rdy, bsy, dn, bt, we, ab, cfg, a, a};
  endfunction

  function automatic logic [25:0] observed();
    return {cmd_ready, busy, done, beat_valid, we_ram, aborted_s, cfgdat, r_addr, w_addr};
  endfunction

  function automatic logic [3:0] cfg_of(input logic [1:0] op);
    case (op)
      2'b00:   return 4'b0010;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1000;
      default: return 4'b1100;
    endcase
  endfunction

  // Queue idle cycles (optionally with stall/abort asserted, which must be ignored).
  task automatic gen_idle(input int n, input logic s, input logic ab);
    stim_t st;
    for (int i = 0; i < n; i++) begin
      st = '0;
      st.stall = s;
      st.abort = ab;
      stim_q.push_back(st);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, last_addr));
    end
  endtask

  // Queue one burst: accept cycle, RUN cycles, DONE cycle.
  // smask bit i = stall in RUN cycle i; abort_at = RUN cycle index carrying abort.
  task automatic gen_burst(input cmd_t c, input logic [31:0] smask, input logic other_stall,
                           input int abort_at, input logic hold_v, input cmd_t hold);
    stim_t      st;
    int         k, i;
    logic       ab, s, a, bt;
    logic [7:0] addr;
    st = '{valid: 1'b1, abort: 1'b0, stall: other_stall, c: c};
    stim_q.push_back(st);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, last_addr));
    k = 0; i = 0; ab = 1'b0;
    while (k < int'(c.len) && !ab) begin
      s    = (i < 32) ? smask[i] : 1'b0;
      a    = (i == abort_at);
      bt   = !s && !a;
      addr = 8'(int'(c.base) + k * int'(c.stride));
      st   = '{valid: hold_v, abort: a, stall: s, c: hold};
      stim_q.push_back(st);
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, bt, bt && !c.op[1], 1'b0, cfg_of(c.op), addr));
      if (a) ab = 1'b1;
      else if (bt) k++;
      i++;
    end
    addr = 8'(int'(c.base) + k * int'(c.stride));
    st = '{valid: hold_v, abort: 1'b0, stall: other_stall, c: hold};
    stim_q.push_back(st);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ab, 4'b0000, addr));
    last_addr = addr;
  endtask

  // Apply queued stimulus one cycle each and record what the DUT shows.
  task automatic drive_all();
    stim_t st;
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      @(negedge clk);
      cmd_valid  = st.valid;
      cmd_op     = st.c.op;
      cmd_base   = st.c.base;
      cmd_stride = st.c.stride;
      cmd_len    = st.c.len;
      stall      = st.stall;
`ifdef DMEM_SEQ_ABORT_EN
      abort      = st.abort;
`endif
      #1;
      act_q.push_back(observed());
    end
    cmd_valid = 1'b0;
    stall     = 1'b0;
`ifdef DMEM_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [25:0] idle_v;
    idle_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00);
    #2;
    n_checks++;
    if (observed() !== idle_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", observed(), idle_v);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Start a len-4 vertical read, then pull reset in the middle of RUN.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_base = 8'h30; cmd_stride = 8'h01; cmd_len = 8'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (observed() !== mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 8'h31)) begin
      n_fail++;
      $display("FAIL reset_pre_run: got %h expected %h", observed(),
               mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 8'h31));
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (observed() !== idle_v) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h expected %h", observed(), idle_v);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (observed() !== idle_v) begin
        n_fail++;
        $display("FAIL reset_after_release cyc %0d: got %h expected %h", i, observed(), idle_v);
      end
    end
    last_addr = 8'h00;
  endtask

  task automatic test_write_burst();
    logic [25:0] e, a;
    int cyc = 0;
    gen_burst('{op: 2'b00, base: 8'h10, stride: 8'h01, len: 8'd4}, 32'h0, 1'b0, -1, 1'b0, '0);
    gen_idle(1, 1'b0, 1'b0);
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL write_burst cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask

  task automatic test_read_wrap();
    logic [25:0] e, a;
    int cyc = 0;
    gen_burst('{op: 2'b11, base: 8'hFE, stride: 8'h03, len: 8'd3}, 32'h0, 1'b0, -1, 1'b0, '0);
    gen_idle(1, 1'b1, 1'b0);
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL read_wrap cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask

  task automatic test_stall();
    logic [25:0] e, a;
    int cyc = 0;
    // Stall on 2nd and 3rd RUN cycles; stall also held in accept and DONE cycles.
    gen_burst('{op: 2'b01, base: 8'h50, stride: 8'h05, len: 8'd3}, 32'b110, 1'b1, -1, 1'b0, '0);
    gen_idle(2, 1'b1, 1'b0);
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask

  task automatic test_zero_len();
    logic [25:0] e, a;
    int cyc = 0;
    gen_burst('{op: 2'b00, base: 8'hA5, stride: 8'h07, len: 8'd0}, 32'h0, 1'b0, -1, 1'b0, '0);
    gen_idle(1, 1'b0, 1'b0);
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL zero_len cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] e, a;
    cmd_t c2;
    int cyc = 0;
    c2 = '{op: 2'b10, base: 8'h40, stride: 8'hFF, len: 8'd2};
    // Second command is held valid throughout the first burst.
    gen_burst('{op: 2'b00, base: 8'h20, stride: 8'h02, len: 8'd3}, 32'h0, 1'b0, -1, 1'b1, c2);
    gen_burst(c2, 32'h0, 1'b0, -1, 1'b0, '0);
    gen_stride0:
    gen_burst('{op: 2'b01, base: 8'h77, stride: 8'h00, len: 8'd2}, 32'h0, 1'b0, -1, 1'b0, '0);
    gen_idle(1, 1'b0, 1'b0);
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask

`ifdef DMEM_SEQ_ABORT_EN
  task automatic test_abort();
    logic [25:0] e, a;
    int cyc = 0;
    gen_idle(1, 1'b0, 1'b1);
    gen_burst('{op: 2'b01, base: 8'h80, stride: 8'h04, len: 8'd8}, 32'h0, 1'b0, 2, 1'b0, '0);
    gen_idle(1, 1'b0, 1'b1);
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL abort cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask
`endif

  task automatic test_random();
    logic [25:0] e, a;
    cmd_t c;
    int cyc = 0;
    for (int b = 0; b < 8; b++) begin
      c.op     = 2'($urandom_range(0, 3));
      c.base   = 8'($urandom_range(0, 255));
      c.stride = 8'($urandom_range(0, 255));
      c.len    = 8'($urandom_range(0, 9));
      gen_burst(c, $urandom() & 32'h0000_0FFF, 1'($urandom_range(0, 1)), -1, 1'b0, '0);
      gen_idle(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    drive_all();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", cyc, a, e);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_stall();
    test_zero_len();
    test_back_to_back();
`ifdef DMEM_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
